// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, datapath widths and the fetch state encoding.
// Imported by fetch, ROM and decode so all stages agree on the instruction format.
package cpu_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 9;
  localparam int OP_W    = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00101;
  localparam logic [OP_W-1:0] OP_LD   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00111;
  localparam logic [OP_W-1:0] OP_JMP  = 5'b11000;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;
  localparam logic [OP_W-1:0] OP_TBD  = 5'b11111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; neither means hold.
// Flush only clears valid: payload of a bubble is don't-care downstream.
module if_id_reg #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, RUN/HALT control and IF/ID capture of the ROM word.
// Optional perf counters (fetch_count, stall_count) when FETCH_PERF_EN is defined.
module instruction_fetch #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count,
`endif
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_e    state, state_n;
  logic [PC_W-1:0] pc_n;
  logic            load, flush;
  logic            is_halt;

  assign is_halt = (instr_in[INSTR_W-1 -: OP_W] == OP_HALT);

  // Priority: redirect > stall > normal. A halt keeps pc on itself so the
  // halted PC stays observable until a redirect releases it.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      pc_n    = redirect_pc;
      flush   = 1'b1;
      state_n = ST_RUN;
    end else if (!stall) begin
      if (state == ST_RUN) begin
        load = 1'b1;
        if (is_halt) state_n = ST_HALT;
        else         pc_n    = pc + 1'b1;
      end else begin
        flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      pc     <= pc_n;
      state  <= state_n;
      halted <= (state_n == ST_HALT);
    end
  end

  if_id_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .instr_d (instr_in),
    .pc_d    (pc),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc      (if_id_pc)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 1'b1;
      if (stall && !redirect_valid && stall_count != 16'hFFFF)
        stall_count <= stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: driver pushes hand-computed expectations
// per edge, a negedge monitor pops and compares against the DUT outputs.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [8:0]  instr_in;
  logic        if_id_valid;
  logic [8:0]  if_id_instr;
  logic [15:0] if_id_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [15:0] pc;
    logic        v;
    logic [15:0] ipc;
    logic        h;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // ROM image: only address 170 holds a halt; everything else is opcode 00001.
  function automatic logic [8:0] rom(input logic [15:0] a);
    if (a == 16'd170) return 9'b11010_0000;
    return {5'b00001, a[3:0]};
  endfunction

  assign instr_in = rom(pc);

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .instr_in       (instr_in),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
`ifdef FETCH_PERF_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .halted         (halted)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", pc, e.pc);
      check("if_id_valid", {15'd0, if_id_valid}, {15'd0, e.v});
      check("halted", {15'd0, halted}, {15'd0, e.h});
      if (e.v) begin
        check("if_id_pc", if_id_pc, e.ipc);
        check("if_id_instr", {7'd0, if_id_instr}, {7'd0, rom(e.ipc)});
      end
    end
  end

  task automatic step(input logic s, input logic rv, input logic [15:0] rpc,
                      input logic [15:0] ep, input logic ev, input logic [15:0] eipc,
                      input logic eh);
    exp_t e;
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    e.pc = ep; e.v = ev; e.ipc = eipc; e.h = eh;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 16'h0000);
    check({tag, "_valid"}, {15'd0, if_id_valid}, 16'd0);
    check({tag, "_instr"}, {7'd0, if_id_instr}, 16'd0);
    check({tag, "_ipc"}, if_id_pc, 16'h0000);
    check({tag, "_halted"}, {15'd0, halted}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // straight-line fetch 0..4
    for (int k = 0; k < 5; k++) step(0, 0, 0, 16'(k + 1), 1, 16'(k), 0);
    // stall 3 cycles at pc=5, IF/ID holds entry 4
    for (int k = 0; k < 3; k++) step(1, 0, 0, 16'd5, 1, 16'd4, 0);
    // resume at 5, run up to pc=20
    for (int p = 5; p < 20; p++) step(0, 0, 0, 16'(p + 1), 1, 16'(p), 0);
    // redirect with simultaneous stall
    step(1, 1, 16'd60, 16'd60, 0, 16'd0, 0);
    step(0, 0, 0, 16'd61, 1, 16'd60, 0);
    // jump near the halt and fetch it
    step(0, 1, 16'd168, 16'd168, 0, 16'd0, 0);
    step(0, 0, 0, 16'd169, 1, 16'd168, 0);
    step(0, 0, 0, 16'd170, 1, 16'd169, 0);
    step(0, 0, 0, 16'd170, 1, 16'd170, 1);
    step(0, 0, 0, 16'd170, 0, 16'd0, 1);
    step(1, 0, 0, 16'd170, 0, 16'd0, 1);
    step(0, 0, 0, 16'd170, 0, 16'd0, 1);
    // cancel halt with redirect to the top of the address space, then wrap
    step(0, 1, 16'hFFFF, 16'hFFFF, 0, 16'd0, 0);
    step(0, 0, 0, 16'h0000, 1, 16'hFFFF, 0);
    step(0, 0, 0, 16'h0001, 1, 16'h0000, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 16'(q.size()), 16'd0);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    check("pre_rst_pc_nonzero", {15'd0, (pc != 16'h0000)}, 16'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined CPU, directly upstream of the instruction ROM and feeding decode. Owns the program counter, drives the ROM address, captures the 9-bit ROM output into the IF/ID pipeline register, and handles stall, branch/jump redirect (with flush) and halt detection. The ROM is combinational on `pc`, so one instruction is fetched per unstalled cycle.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `PC_W`, 16: program counter width; matches the ROM address port.
- `INSTR_W`, 9: instruction width, made of a 5-bit opcode and a 4-bit operand.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `stall`  in  1: decode cannot accept. Hold PC and the IF/ID register.
- `redirect_valid`  in  1: branch/jump resolved taken downstream.
- `redirect_pc`  in  PC_W: target address for the redirect.
- `pc`  out  PC_W: fetch address, wired to the ROM `pc` input.
- `instr_in`  in  INSTR_W: ROM `instruction` output for the current `pc`.
- `if_id_valid`  out  1: IF/ID register holds a real instruction; 0 means bubble.
- `if_id_instr`  out  INSTR_W: latched instruction.
- `if_id_pc`  out  PC_W: address the latched instruction was fetched from.
- `halted`  out  1: fetch is stopped in the HALT state.

## Operation
- States are RUN and HALT.
- Per-edge priority is redirect, then stall, then normal.
- Redirect (either state):
  - `pc`←`redirect_pc`.
  - `if_id_valid`←0, flushing the wrong-path instruction.
  - Next state is RUN.
  - Redirect overrides a simultaneous stall.
- Stall (no redirect): `pc`, `if_id_*` and the state all hold.
- RUN, normal cycle:
  - `if_id_instr`←`instr_in`, `if_id_pc`←`pc`, `if_id_valid`←1.
  - If `instr_in[8:4]` is the halt opcode (5'b11010): `pc` holds and the state goes to HALT.
  - Otherwise `pc`←`pc`+1, modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000.
- HALT, normal cycle:
  - `pc` frozen, `if_id_valid`←0.
  - Only a redirect exits HALT; this covers a halt fetched on a mispredicted path.
- Each halt instruction is passed to decode exactly once, with `if_id_valid`=1.
- Reset values: `pc`=RESET_PC, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0, state RUN, `halted`=0.
- Reset asserted mid-operation discards all in-flight state immediately, without waiting for a clock edge.
- `halted` is a registered output that equals (state==HALT).

## Timing
- ROM path is combinational: `instr_in` is valid in the same cycle `pc` is driven.
- Fetch-to-decode latency is 1 cycle. The instruction at `pc` in cycle N appears on `if_id_instr` in cycle N+1.
- Redirect penalty:
  - The redirect in cycle N produces a bubble on `if_id_valid` in cycle N+1.
  - The target instruction appears in cycle N+2.
- First instruction after reset release appears on IF/ID one edge later.
- `halted` rises on the same edge that latches the halt instruction into IF/ID.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `fetch_count` (16 bits): increments on every edge that sets `if_id_valid`←1.
  - Adds output `stall_count` (16 bits): increments on every edge with `stall`=1 and no redirect.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - the 5-bit opcode localparams (add through toBeDefined, including `OP_HALT`=5'b11010);
  - `PC_W` and `INSTR_W`;
  - the fetch state enum (RUN, HALT).
- The ROM and decode modules import the same package.
- One sub-module, `if_id_reg`: the IF/ID pipeline register with load, flush and hold controls and asynchronous active-low reset.
- The PC register and the state machine live in `instruction_fetch`.

## Test plan
- **Reset and straight-line fetch.** Reset, then release, with ROM words at 0..2 not halt.
  - `if_id_pc` goes 0, 1, 2 on consecutive cycles.
  - `if_id_valid`=1 from the first edge after release.
- **Stall.** Assert `stall` for 3 cycles while `pc`=5.
  - `pc` stays 5.
  - `if_id_instr` and `if_id_pc` hold the pc-4 entry for 3 cycles.
  - Fetch resumes at 5.
- **Redirect.** Assert `redirect_valid` with `redirect_pc`=16'd60 while `pc`=20, with `stall` also high.
  - Next cycle: `if_id_valid`=0 and `pc`=60.
  - Following cycle: `if_id_pc`=60, `if_id_valid`=1.
- **Halt.** ROM returns 9'b11010_0000 at `pc`=170.
  - `if_id_instr` shows the halt once with `if_id_valid`=1.
  - `halted`=1 and `pc` stays 170.
  - `if_id_valid`=0 on all later cycles.
- **Halt cancel and wrap.**
  - While halted, redirect to 16'hFFFF: `halted`=0 and `if_id_pc`=16'hFFFF, then 16'h0000.
  - Then assert `rst_n`=0 asynchronously mid-cycle: all outputs reset immediately, before the next edge.
